// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared constants and types for the data-memory bridge.
// Holds MMIO register offsets (address[3:2]), STATUS bit positions and the
// address-region select enum used by the bridge decoder.
package dmem_bridge_pkg;

  // MMIO register offsets, indexed by address[3:2]
  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_LED    = 2'd3;

  // STATUS register bit positions
  localparam int unsigned ST_FULL   = 0;
  localparam int unsigned ST_EMPTY  = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_CNT_LSB = 8;

  // Address decode result
  typedef enum logic [1:0] {
    RAM      = 2'd0,
    MMIO     = 2'd1,
    UNMAPPED = 2'd2
  } region_e;

endpackage : dmem_bridge_pkg

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head.
// Latency: a push is visible on o_head/o_empty the cycle after its edge.
// Backpressure: push dropped when full unless a pop happens the same cycle.
// Ports: clk, reset (sync, active-high); i_push/i_push_dat write side;
//        i_pop consume head (ignored when empty); o_full, o_empty, o_count,
//        o_head (0 while empty).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  // When full, the slot at r_wr_ptr is the head being popped this edge,
  // so the incoming byte can take it.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule : sync_fifo

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: CPU data-memory port to word RAM + MMIO (console TX, LED, cycle counter).
// Latency: reads combinational same cycle; writes take effect at the rising edge.
// Backpressure: none toward the cpu; rejected writes dropped (FIFO overflow / bus_err_o).
// Ports: clk, reset (sync, active-high); data_mem_we_i/address_i/write_i/read_o cpu side;
//        tx_data_o/tx_valid_o/tx_ready_i console stream; led_o; bus_err_o.
// Optional: define DMEM_BRIDGE_CYCLE_CNT_EN to build the CYCLE counter (else offset 2 reads 0).
module data_mem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  data_mem_we_i,
  input  logic [31:0] data_mem_address_i,
  input  logic [31:0] data_mem_write_i,
  output logic [31:0] data_mem_read_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  led_o,
  output logic        bus_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(DEPTH_WORDS * 4);

  // ---------------- decode ----------------
  region_e     w_region;
  logic [1:0]  w_off;
  logic        w_wr;
  logic [AW-1:0] w_widx;

  always_comb begin
    w_region = UNMAPPED;
    if (data_mem_address_i < RAM_LIMIT)
      w_region = RAM;
    else if (data_mem_address_i[31:4] == MMIO_BASE[31:4])
      w_region = MMIO;
  end

  assign w_off  = data_mem_address_i[3:2];
  assign w_wr   = |data_mem_we_i;
  assign w_widx = data_mem_address_i[AW+1:2];

  logic w_mmio_wr;
  logic w_push_req;
  logic w_status_clr;
  logic w_led_ld;

  assign w_mmio_wr    = w_wr && (w_region == MMIO);
  assign w_push_req   = w_mmio_wr && (w_off == OFF_TX) && data_mem_we_i[0];
  assign w_status_clr = w_mmio_wr && (w_off == OFF_STATUS);
  assign w_led_ld     = w_mmio_wr && (w_off == OFF_LED) && data_mem_we_i[0];

  // ---------------- RAM ----------------
  logic [31:0] r_ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!reset && w_wr && (w_region == RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (data_mem_we_i[i]) r_ram[w_widx][8*i +: 8] <= data_mem_write_i[8*i +: 8];
      end
    end
  end

  // ---------------- console FIFO ----------------
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push_req),
    .i_push_dat (data_mem_write_i[7:0]),
    .i_pop      (tx_ready_i),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  // Full with no pop is the only drop case; full with tx_ready_i pops (non-empty).
  logic w_ovf_set;
  assign w_ovf_set = w_push_req && w_full && !tx_ready_i;

  logic r_ovf;
  logic [7:0] r_led;
  logic r_bus_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_led     <= 8'h00;
      r_bus_err <= 1'b0;
    end else begin
      if (w_ovf_set)         r_ovf <= 1'b1;
      else if (w_status_clr) r_ovf <= 1'b0;
      if (w_led_ld) r_led <= data_mem_write_i[7:0];
      r_bus_err <= w_wr && (w_region == UNMAPPED);
    end
  end

  // ---------------- cycle counter ----------------
  logic [31:0] w_cycle;
`ifdef DMEM_BRIDGE_CYCLE_CNT_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clk) begin
    if (reset) r_cycle <= '0;
    else       r_cycle <= r_cycle + 32'd1;
  end
  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  // ---------------- read mux ----------------
  logic [31:0] w_status;
  always_comb begin
    w_status                        = '0;
    w_status[ST_FULL]               = w_full;
    w_status[ST_EMPTY]              = w_empty;
    w_status[ST_OVF]                = r_ovf;
    w_status[ST_CNT_LSB +: 8]       = 8'(w_count);
  end

  always_comb begin
    data_mem_read_o = '0;
    case (w_region)
      RAM:  data_mem_read_o = r_ram[w_widx];
      MMIO: begin
        case (w_off)
          OFF_STATUS: data_mem_read_o = w_status;
          OFF_CYCLE:  data_mem_read_o = w_cycle;
          OFF_LED:    data_mem_read_o = {24'b0, r_led};
          default:    data_mem_read_o = '0;
        endcase
      end
      default: data_mem_read_o = '0;
    endcase
  end

  assign tx_data_o  = w_head;
  assign tx_valid_o = ~w_empty;
  assign led_o      = r_led;
  assign bus_err_o  = r_bus_err;

endmodule : data_mem_bridge
